// File: rtl/simple_cpu.sv
// Memory-to-memory CPU with no register file: each instruction reads its operands from
// RAM, computes, and writes the result back to RAM.
module simple_cpu #(
  parameter int unsigned SIZE = 10
) (
  input  logic            clk,
  input  logic            rst,
  output logic            wrEn,
  input  logic [31:0]     data_fromRAM,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM
);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpNand = 3'd1;
  localparam logic [2:0] OpSrl  = 3'd2;
  localparam logic [2:0] OpLt   = 3'd3;
  localparam logic [2:0] OpCp   = 3'd4;
  localparam logic [2:0] OpCpi  = 3'd5;
  localparam logic [2:0] OpBzj  = 3'd6;
  localparam logic [2:0] OpMul  = 3'd7;

  localparam logic [SIZE-1:0] PcOne = SIZE'(1);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StReadA,
    StExec,
    StIndir,
    StWrBack
  } state_e;

  state_e          stateQ, stateD;
  logic [SIZE-1:0] pcQ, pcD;
  logic [31:0]     iwQ, raQ, rbQ;

  logic [2:0]      opcode;
  logic            imm;
  logic [SIZE-1:0] aAddr, bAddr;
  logic [13:0]     bField;
  logic [31:0]     operandV;
  logic [31:0]     aluResult;
  logic [31:0]     bzjSum;
  logic            unusedBits;

  assign opcode   = iwQ[31:29];
  assign imm      = iwQ[28];
  assign aAddr    = iwQ[SIZE+13:14];
  assign bAddr    = iwQ[SIZE-1:0];
  assign bField   = iwQ[13:0];
  // In EXEC the RAM is returning *B, so the register operand comes straight off the bus.
  assign operandV = imm ? {18'd0, bField} : data_fromRAM;
  assign bzjSum   = raQ + {18'd0, bField};

  // Only the low SIZE bits of the A field and of *B act as addresses.
  assign unusedBits = ^{iwQ, rbQ};

  always_comb begin
    aluResult = '0;
    case (opcode)
      OpAdd:  aluResult = raQ + operandV;
      OpNand: aluResult = ~(raQ & operandV);
      OpSrl: begin
        // V in [32,63] shifts left by V-32, whose low five bits equal V[4:0].
        if (operandV < 32'd32) begin
          aluResult = raQ >> operandV[4:0];
        end else if (operandV < 32'd64) begin
          aluResult = raQ << operandV[4:0];
        end else begin
          aluResult = '0;
        end
      end
      OpLt:   aluResult = {31'd0, raQ < operandV};
      OpCp:   aluResult = operandV;
      OpMul:  aluResult = raQ * operandV;
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = StFetch;
    unique case (stateQ)
      StFetch:  stateD = StDecode;
      StDecode: stateD = StReadA;
      StReadA:  stateD = StExec;
      StExec:   stateD = (opcode == OpCpi && !imm) ? StIndir : StFetch;
      StIndir:  stateD = StWrBack;
      StWrBack: stateD = StFetch;
      default:  stateD = StFetch;
    endcase
  end

  always_comb begin
    wrEn       = 1'b0;
    addr_toRAM = pcQ;
    data_toRAM = '0;
    pcD        = pcQ;
    unique case (stateQ)
      StFetch:  addr_toRAM = pcQ;
      StDecode: addr_toRAM = data_fromRAM[SIZE+13:14];
      StReadA:  addr_toRAM = bAddr;
      StExec: begin
        case (opcode)
          OpCpi: begin
            addr_toRAM = aAddr;
            if (imm) begin
              wrEn       = 1'b1;
              addr_toRAM = raQ[SIZE-1:0];
              data_toRAM = data_fromRAM;
              pcD        = pcQ + PcOne;
            end
          end
          OpBzj: begin
            addr_toRAM = aAddr;
            if (imm) begin
              pcD = bzjSum[SIZE-1:0];
            end else begin
              pcD = (data_fromRAM == '0) ? raQ[SIZE-1:0] : pcQ + PcOne;
            end
          end
          default: begin
            wrEn       = 1'b1;
            addr_toRAM = aAddr;
            data_toRAM = aluResult;
            pcD        = pcQ + PcOne;
          end
        endcase
      end
      StIndir:  addr_toRAM = rbQ[SIZE-1:0];
      StWrBack: begin
        wrEn       = 1'b1;
        addr_toRAM = aAddr;
        data_toRAM = data_fromRAM;
        pcD        = pcQ + PcOne;
      end
      default: begin
        wrEn       = 1'b0;
        addr_toRAM = pcQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcQ <= '0;
      iwQ <= '0;
      raQ <= '0;
      rbQ <= '0;
    end else begin
      pcQ <= pcD;
      if (stateQ == StDecode) iwQ <= data_fromRAM;
      if (stateQ == StReadA)  raQ <= data_fromRAM;
      if (stateQ == StExec)   rbQ <= data_fromRAM;
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Bench for simple_cpu: synchronous-read RAM, an instruction-level reference model that
// predicts every bus cycle, directed programs with literal expectations, and random memories.
module tb_simple_cpu;

  localparam int unsigned MemWords = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrEn;
  logic [31:0] dataFromRam;
  logic [9:0]  addrToRam;
  logic [31:0] dataToRam;

  logic        ldEn   = 1'b0;
  logic [9:0]  ldAddr = '0;
  logic [31:0] ldData = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [MemWords];
  logic [31:0] mdl [MemWords];
  logic [9:0]  mPc;

  typedef struct {
    bit          wr;
    bit          ckAddr;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;
  ev_t evQ[$];

  simple_cpu #(.SIZE(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .wrEn        (wrEn),
    .data_fromRAM(dataFromRam),
    .addr_toRAM  (addrToRam),
    .data_toRAM  (dataToRam)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ldEn) ram[ldAddr] <= ldData;
    else if (wrEn) ram[addrToRam] <= dataToRam;
    dataFromRam <= ram[addrToRam];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] v);
    longint unsigned p;
    case (op)
      3'd0: return a + v;
      3'd1: return ~(a & v);
      3'd2: begin
        if (v < 32) return a / (32'd1 << v);
        if (v < 64) begin
          p = 64'(a) * (64'd1 << (v - 32));
          return p[31:0];
        end
        return 32'd0;
      end
      3'd3: return (a < v) ? 32'd1 : 32'd0;
      3'd4: return v;
      default: begin
        p = 64'(a) * 64'(v);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic void pushEv(input bit wr, input bit ck, input logic [9:0] ad,
                                 input logic [31:0] d);
    ev_t e;
    e.wr = wr; e.ckAddr = ck; e.addr = ad; e.data = d;
    evQ.push_back(e);
  endfunction

  // Executes one instruction on the model memory and queues the bus cycles it must produce.
  function automatic void modelStep();
    logic [31:0] iw, va, vb, v;
    logic [2:0]  op;
    logic [9:0]  a, b, ptr;
    bit          imm;
    iw  = mdl[mPc];
    op  = iw[31:29];
    imm = iw[28];
    a   = iw[23:14];
    b   = iw[9:0];
    va  = mdl[a];
    vb  = mdl[b];
    v   = imm ? 32'(iw[13:0]) : vb;
    pushEv(1'b0, 1'b1, mPc, '0);
    pushEv(1'b0, 1'b1, a, '0);
    pushEv(1'b0, 1'b1, b, '0);
    if (op == 3'd5 && !imm) begin
      ptr = vb[9:0];
      pushEv(1'b0, 1'b0, '0, '0);
      pushEv(1'b0, 1'b1, ptr, '0);
      pushEv(1'b1, 1'b1, a, mdl[ptr]);
      mPc = mPc + 10'd1;
    end else if (op == 3'd5) begin
      pushEv(1'b1, 1'b1, va[9:0], vb);
      mPc = mPc + 10'd1;
    end else if (op == 3'd6) begin
      pushEv(1'b0, 1'b0, '0, '0);
      if (imm) mPc = 10'((va + 32'(iw[13:0])) % MemWords);
      else     mPc = (vb == 0) ? va[9:0] : mPc + 10'd1;
    end else begin
      pushEv(1'b1, 1'b1, a, aluRef(op, va, v));
      mPc = mPc + 10'd1;
    end
  endfunction

  // Single compare process: reset values while rst is high, model-predicted cycles otherwise.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (ldEn) mdl[ldAddr] = ldData;
      evQ.delete();
      mPc = '0;
      chk("rst_wrEn", 32'(wrEn), 32'd0);
      chk("rst_addr", 32'(addrToRam), 32'd0);
      chk("rst_data", dataToRam, 32'd0);
    end else begin
      if (evQ.size() == 0) modelStep();
      e = evQ.pop_front();
      chk("cyc_wrEn", 32'(wrEn), 32'(e.wr));
      if (e.ckAddr) chk("cyc_addr", 32'(addrToRam), 32'(e.addr));
      if (e.wr) begin
        chk("cyc_wdata", dataToRam, e.data);
        mdl[e.addr] = e.data;
      end
    end
  end

  task automatic loadWord(input int unsigned a, input logic [31:0] d);
    ldEn = 1'b1; ldAddr = 10'(a); ldData = d;
    @(posedge clk); #1;
    ldEn = 1'b0;
  endtask

  task automatic enterReset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic runCount(input int n, output int writes);
    writes = 0;
    repeat (n) begin
      @(negedge clk);
      if (wrEn) writes++;
    end
  endtask

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 70));
      2: return {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 14'($urandom_range(0, 1023)), 14'($urandom_range(0, 1023))};
      default: return 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // One directed single-instruction test: program at 0, operands at 50/51.
  task automatic oneInstr(input logic [31:0] iw, input logic [31:0] m50, input logic [31:0] m51);
    enterReset();
    loadWord(0, iw);
    loadWord(50, m50);
    loadWord(51, m51);
    rst = 1'b0;
  endtask

  initial begin
    int w, w2;
    for (int i = 0; i < int'(MemWords); i++) loadWord(i, 32'd0);

    // Reset held, then released mid-instruction with a pending write.
    chk("hold_wrEn", 32'(wrEn), 32'd0);
    chk("hold_addr", 32'(addrToRam), 32'd0);
    loadWord(0, 32'h000C8033);
    loadWord(50, 32'd5);
    loadWord(51, 32'd7);
    rst = 1'b0;
    waitNeg(3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_wrEn", 32'(wrEn), 32'd0);
    chk("mid_rst_addr", 32'(addrToRam), 32'd0);
    waitNeg(3);
    chk("mid_rst_nowrite", ram[50], 32'd5);
    @(posedge clk); #1;
    rst = 1'b0;
    waitNeg(1);
    chk("first_fetch", 32'(addrToRam), 32'd0);

    // ADD: A=50, B=51, 5+7.
    oneInstr(32'h000C8033, 32'd5, 32'd7);
    waitNeg(4);
    chk("add_wrEn", 32'(wrEn), 32'd1);
    chk("add_addr", 32'(addrToRam), 32'd50);
    chk("add_data", dataToRam, 32'd12);
    waitNeg(1);
    chk("add_next", 32'(addrToRam), 32'd1);

    oneInstr(32'h900C8064, 32'd0, 32'd0);
    waitNeg(5);
    chk("cp_imm", ram[50], 32'd100);
    oneInstr(32'h500C8003, 32'h80, 32'd0);
    waitNeg(5);
    chk("srl_3", ram[50], 32'h10);
    oneInstr(32'h500C8021, 32'h80, 32'd0);
    waitNeg(5);
    chk("srl_33", ram[50], 32'h100);

    oneInstr(32'hC00C8033, 32'd20, 32'd0);
    waitNeg(4);
    chk("bzj_nowr", 32'(wrEn), 32'd0);
    waitNeg(1);
    chk("bzj_taken", 32'(addrToRam), 32'd20);
    oneInstr(32'hC00C8033, 32'd20, 32'd3);
    waitNeg(5);
    chk("bzj_fall", 32'(addrToRam), 32'd1);
    oneInstr(32'hD00C8005, 32'd20, 32'd3);
    waitNeg(5);
    chk("bzji", 32'(addrToRam), 32'd25);

    // CPI indirect read: *50 = **51 = mem[60].
    enterReset();
    loadWord(60, 32'd9);
    oneInstr(32'hA00C8033, 32'd0, 32'd60);
    waitNeg(6);
    chk("cpi_wrEn", 32'(wrEn), 32'd1);
    chk("cpi_addr", 32'(addrToRam), 32'd50);
    chk("cpi_data", dataToRam, 32'd9);
    waitNeg(1);
    chk("cpi_mem", ram[50], 32'd9);
    chk("cpi_next", 32'(addrToRam), 32'd1);
    oneInstr(32'hB00C8033, 32'd70, 32'h0000_1234);
    waitNeg(5);
    chk("cpii_mem", ram[70], 32'h0000_1234);

    // Sum 1..10 into mem[50], then halt on a self-loop.
    enterReset();
    loadWord(0, 32'h900C8000);
    loadWord(1, 32'h900CC00A);
    loadWord(2, 32'h000C8033);
    loadWord(3, 32'h000CC034);
    loadWord(4, 32'hC00D4033);
    loadWord(5, 32'hD00D8002);
    loadWord(6, 32'hC00DC038);
    loadWord(52, 32'hFFFF_FFFF);
    loadWord(53, 32'd6);
    loadWord(54, 32'd0);
    loadWord(55, 32'd6);
    loadWord(56, 32'd0);
    rst = 1'b0;
    runCount(200, w);
    runCount(200, w2);
    chk("sum_result", ram[50], 32'd55);
    chk("sum_counter", ram[51], 32'd0);
    chk("sum_writes", 32'(w), 32'd22);
    chk("halt_writes", 32'(w2), 32'd0);

    // Random memories, one with an asynchronous reset in the middle of the run.
    for (int r = 0; r < 3; r++) begin
      enterReset();
      for (int i = 0; i < int'(MemWords); i++) loadWord(i, randWord());
      rst = 1'b0;
      if (r == 1) begin
        waitNeg(150 + $urandom_range(0, 5));
        @(posedge clk); #1;
        rst = 1'b1;
        waitNeg(2);
        @(posedge clk); #1;
        rst = 1'b0;
      end
      waitNeg(500);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
